fpu_issue_arbiter: RTL
======================

FPU_ISSUE_ARBITER -- requirements
Module: fpu_issue_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 4: cycles from fpu_valid_o to the matching fpu_valid_i, range 1..16.
REQ-002 SHALL have parameter MAX_OUT, default 4: maximum in-flight operations per requester, range 1..15.
REQ-003 SHALL have one clock and an asynchronous active-low reset, both listed first:
- clk_i  input  1  clock
- rst_ni  input  1  reset
REQ-004 SHALL have these requester ports:
- req_valid_i  input  [1:0]  operand pair offered, one bit per requester
- req_ready_o  output  [1:0]  operand pair accepted this cycle
- req_a_i  input  2 x float_point_num  operand A per requester
- req_b_i  input  2 x float_point_num  operand B per requester
REQ-005 SHALL have these pipelined-FPU ports:
- fpu_valid_o  output  1  issue strobe to the pipelined FPU
- fpu_a_o  output  float_point_num  issued operand A
- fpu_b_o  output  float_point_num  issued operand B
- fpu_valid_i  input  1  FPU result strobe
- fpu_res_i  input  float_point_num  FPU result
REQ-006 SHALL have these response and status ports:
- rsp_valid_o  output  [1:0]  result strobe per requester, no backpressure
- rsp_res_o  output  float_point_num  result, shared by both requesters
- busy_o  output  1  any operation in flight
- err_o  output  1  sticky protocol error

Function
REQ-007 SHALL grant at most one requester per cycle; req_ready_o[i] is combinational and high only when requester i is granted.
REQ-008 SHALL make requester i eligible when req_valid_i[i]=1 and out_cnt[i] < MAX_OUT.
REQ-009 SHALL arbitrate round-robin using rr_ptr, which holds the requester preferred next:
- both eligible: grant rr_ptr
- one eligible: grant that one
- rr_ptr updates to the non-granted index after every handshake only.
REQ-010 SHALL register the issue: a handshake in cycle N drives fpu_valid_o=1 with the granted operands in cycle N+1; with no handshake, fpu_valid_o=0 and the operands hold their last value.
REQ-011 SHALL shift a LATENCY-deep pipe of {valid, id} in lockstep with issue, so the id of each issued operation reaches the head exactly when fpu_valid_i returns.
REQ-012 SHALL register the response: fpu_valid_i=1 in cycle M with a valid head entry gives rsp_valid_o[id]=1 and rsp_res_o=fpu_res_i in cycle M+1.
REQ-013 SHALL keep a 4-bit out_cnt per requester:
- increments on that requester's handshake
- decrements when its rsp_valid_o pulses
- both in the same cycle: unchanged
- never wraps.
REQ-014 SHALL set err_o (sticky until reset) and suppress rsp_valid_o when:
- fpu_valid_i=1 with an invalid head entry, or
- a valid head entry sees fpu_valid_i=0.
REQ-015 SHALL drive busy_o = (out_cnt[0] != 0) or (out_cnt[1] != 0).
REQ-016 SHALL sustain back-to-back issue of one operation per cycle.

Reset
REQ-017 SHALL clear on reset assertion:
- fpu_valid_o, rsp_valid_o, err_o, busy_o = 0
- operand/result registers = 0
- tag pipe invalid, out_cnt = 0, rr_ptr = 0.
REQ-018 SHALL discard all in-flight operations when reset asserts mid-operation; results arriving after reset release set err_o.

Configuration
REQ-019 SHALL compile 16-bit saturating per-requester grant counters (perf_grant_o, output 2 x 16) when FPU_ISSUE_ARB_PERF_EN is defined; counters reset to 0 and increment on each handshake.
REQ-020 SHALL omit perf_grant_o and the counters entirely when FPU_ISSUE_ARB_PERF_EN is undefined.

Structure
REQ-021 SHALL take float_point_num from float_types_pkg and add to that package a 1-bit requester-id typedef and a tag-entry struct {valid, id}.
REQ-022 SHALL place the tag pipe in one sub-module, fpu_tag_pipe, parameterised by LATENCY.

Verification
REQ-023 Single request: req_valid_i=01, A=3F800000, B=40000000, FPU model LATENCY=4 -> req_ready_o=01 at cycle 0, fpu_valid_o at cycle 1, rsp_valid_o=01 at cycle 6.
REQ-024 Both requesters valid for 6 cycles from reset -> grants alternate 0,1,0,1,0,1; responses return in issue order.
REQ-025 MAX_OUT=2, requester 0 held valid, FPU stalled -> exactly 2 grants, then req_ready_o[0]=0 until the first rsp_valid_o[0].
REQ-026 Spurious fpu_valid_i with an empty pipe -> err_o=1, rsp_valid_o stays 00, err_o stays 1 until reset.
REQ-027 rst_ni pulsed low with 3 operations in flight -> all outputs 0 immediately, busy_o=0, returning results set err_o.

Source files
------------

// File: rtl/float_types_pkg.sv
// Shared floating-point operand type plus the requester-id and tag-entry types
// used by the FPU issue arbiter and its tag pipe.
package float_types_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } float_point_num;

    typedef logic req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_entry_t;

endpackage

// File: rtl/fpu_tag_pipe.sv
// Fixed-depth shift register of {valid, id} tags that tracks operations through
// the pipelined FPU; the head lines up with the FPU result strobe.
module fpu_tag_pipe
    import float_types_pkg::*;
#(
    parameter int unsigned LATENCY = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  tag_entry_t entry_i,
    output tag_entry_t head_o
);

    tag_entry_t stage_q [LATENCY];

    // Shifts every cycle: the FPU never stalls, so the tag must too.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= entry_i;
            for (int i = 1; i < LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign head_o = stage_q[LATENCY-1];

endmodule

// File: rtl/fpu_issue_arbiter.sv
// Two-requester round-robin issue arbiter in front of a fixed-latency pipelined FPU.
// Define FPU_ISSUE_ARB_PERF_EN to add saturating per-requester grant counters.
module fpu_issue_arbiter
    import float_types_pkg::*;
#(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [1:0]           req_valid_i,
    output logic [1:0]           req_ready_o,
    input  float_point_num [1:0] req_a_i,
    input  float_point_num [1:0] req_b_i,
    output logic                 fpu_valid_o,
    output float_point_num       fpu_a_o,
    output float_point_num       fpu_b_o,
    input  logic                 fpu_valid_i,
    input  float_point_num       fpu_res_i,
    output logic [1:0]           rsp_valid_o,
    output float_point_num       rsp_res_o,
    output logic                 busy_o,
    output logic                 err_o
`ifdef FPU_ISSUE_ARB_PERF_EN
    ,
    output logic [1:0][15:0]     perf_grant_o
`endif
);

    localparam logic [3:0] CNT_LIMIT = 4'(MAX_OUT);

    logic [1:0][3:0] out_cnt;
    req_id_t         rr_ptr;
    req_id_t         grant_id;
    req_id_t         issue_id;
    logic [1:0]      eligible;
    logic            handshake;
    logic            rsp_ok;
    tag_entry_t      head;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            eligible[i] = req_valid_i[i] && (out_cnt[i] < CNT_LIMIT);
        end
    end

    always_comb begin
        grant_id    = rr_ptr;
        req_ready_o = '0;
        case (eligible)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            default: grant_id = rr_ptr;
        endcase
        handshake = |eligible;
        if (handshake) begin
            req_ready_o[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fpu_valid_o <= 1'b0;
            fpu_a_o     <= '0;
            fpu_b_o     <= '0;
            issue_id    <= '0;
            rr_ptr      <= '0;
        end else begin
            fpu_valid_o <= handshake;
            if (handshake) begin
                fpu_a_o  <= req_a_i[grant_id];
                fpu_b_o  <= req_b_i[grant_id];
                issue_id <= grant_id;
                rr_ptr   <= ~grant_id;
            end
        end
    end

    fpu_tag_pipe #(
        .LATENCY (LATENCY)
    ) u_tag_pipe (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .entry_i ('{valid: fpu_valid_o, id: issue_id}),
        .head_o  (head)
    );

    assign rsp_ok = fpu_valid_i && head.valid;

    // A result without a tag, or a tag without a result, means the FPU and the
    // tag pipe have lost lockstep; nothing after that can be trusted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_o <= '0;
            rsp_res_o   <= '0;
            err_o       <= 1'b0;
        end else begin
            rsp_valid_o <= '0;
            if (rsp_ok) begin
                rsp_valid_o[head.id] <= 1'b1;
                rsp_res_o            <= fpu_res_i;
            end
            if (fpu_valid_i != head.valid) begin
                err_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_cnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (req_ready_o[i] && !rsp_valid_o[i] && out_cnt[i] != 4'hF) begin
                    out_cnt[i] <= out_cnt[i] + 4'd1;
                end else if (rsp_valid_o[i] && !req_ready_o[i] && out_cnt[i] != 4'h0) begin
                    out_cnt[i] <= out_cnt[i] - 4'd1;
                end
            end
        end
    end

    assign busy_o = (out_cnt[0] != 4'h0) || (out_cnt[1] != 4'h0);

`ifdef FPU_ISSUE_ARB_PERF_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_grant_o <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (req_ready_o[i] && perf_grant_o[i] != 16'hFFFF) begin
                    perf_grant_o[i] <= perf_grant_o[i] + 16'd1;
                end
            end
        end
    end
`endif

endmodule
